ps2_scancode_rx: RTL and testbench

- PS/2 device-to-host receiver.
- Synchronises and deglitches the raw ps2_clk/ps2_data pins, deserialises 11-bit frames, and checks start, parity and stop bits.
- Folds the E0 (extended) and F0 (break) prefix bytes into a single decoded key event per scan code.
- Sits directly upstream of keyboardInput, which maps events to note, arrow and octave keys.

---
 rtl/ps2_scancode_rx.sv | 246 ++++++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
// PS/2 device-to-host receiver. Conditions the raw ps2_clk/ps2_data pins,
// deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop),
// and folds the E0 (extended) and F0 (break) prefixes into one key event
// per scan code for the downstream keyboardInput block.
// The block only listens; it never drives the PS/2 pins.

module ps2_scancode_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       code_ext,
  output logic       code_break,
  output logic       frame_err
);

  // Filter counter counts mismatching samples; it flips the filtered level
  // on the FILT_LEN-th consecutive mismatch.
  localparam int             FC_W      = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0] FILT_LAST = FC_W'(FILT_LEN - 1);

  // Timeout counter fires on the cycle it holds TIMEOUT_CYCLES-1, i.e. the
  // TIMEOUT_CYCLES-th consecutive cycle without a falling edge.
  localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Input conditioning
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;
  logic                   filt_clk;
  logic                   filt_prev;
  logic [FC_W-1:0]        filt_cnt;
  logic                   fall_edge;

  // Frame receiver
  state_t                 state;
  state_t                 state_next;
  logic [7:0]             shift_reg;
  logic [2:0]             bit_cnt;
  logic                   parity_bit;
  logic [TO_W-1:0]        to_cnt;
  logic                   frame_ok;
  logic                   stop_good;
  logic                   stop_bad;
  logic                   timeout_hit;

  // Pipeline between frame receiver and prefix decoder
  logic                   byte_done;
  logic [7:0]             byte_q;
  logic                   frame_bad;

  // Prefix decoder
  logic                   ext_pending;
  logic                   brk_pending;

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign fall_edge = filt_prev & ~filt_clk;

  // Good frame: data plus parity holds an odd number of ones and stop bit is 1.
  assign frame_ok  = (^{shift_reg, parity_bit}) & data_s;

  // Multi-flop synchronisers; preset high so reset looks like an idle bus.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Deglitch ps2_clk: follow the synchronised level only after FILT_LEN equal samples.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a falling edge in the terminal-count cycle beats the timeout.
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    stop_good   = 1'b0;
    stop_bad    = 1'b0;
    if ((state != IDLE) && !fall_edge && (to_cnt == TO_LAST)) begin
      timeout_hit = 1'b1;
      state_next  = IDLE;
    end else if (fall_edge) begin
      case (state)
        IDLE: begin
          if (!data_s) begin
            state_next = DATA;
          end
        end
        DATA: begin
          if (bit_cnt == 3'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (frame_ok) begin
            stop_good = 1'b1;
          end else begin
            stop_bad = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Shift register, bit counter and parity capture, all sampled on the falling edge.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
    end else if (fall_edge) begin
      case (state)
        IDLE: begin
          if (!data_s) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end
        DATA: begin
          shift_reg <= {data_s, shift_reg[7:1]};
          bit_cnt   <= bit_cnt + 3'd1;
        end
        PARITY: begin
          parity_bit <= data_s;
        end
        default: begin
        end
      endcase
    end
  end

  // Abandon a partial frame when the device stops clocking mid-frame.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      to_cnt <= '0;
    end else if ((state == IDLE) || fall_edge || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // First pipeline stage: byte_done / frame_bad pulses, byte captured with them.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      byte_done <= 1'b0;
      byte_q    <= '0;
      frame_bad <= 1'b0;
    end else begin
      byte_done <= stop_good;
      frame_bad <= stop_bad | timeout_hit;
      if (stop_good) begin
        byte_q <= shift_reg;
      end
    end
  end

  // Prefix decoder and output register; errors drop any half-built prefix sequence.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      code_valid  <= 1'b0;
      code        <= '0;
      code_ext    <= 1'b0;
      code_break  <= 1'b0;
      frame_err   <= 1'b0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= frame_bad;
      if (frame_bad) begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (byte_done) begin
        if (byte_q == PREFIX_EXT) begin
          ext_pending <= 1'b1;
        end else if (byte_q == PREFIX_BRK) begin
          brk_pending <= 1'b1;
        end else begin
          code_valid  <= 1'b1;
          code        <= byte_q;
          code_ext    <= ext_pending;
          code_break  <= brk_pending;
          ext_pending <= 1'b0;
          brk_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx
// Self-checking bench for ps2_scancode_rx. Frames are driven on the pins at
// a scaled-down PS/2 rate; a scoreboard of expected key events and frame
// errors is built from the protocol rules and compared against every
// code_valid / frame_err pulse, including the fixed output latency.

module tb_ps2_scancode_rx;

  localparam int TB_TIMEOUT = 3000;
  localparam int HALF       = 40;
  // Pin edge -> 2 sync flops -> 8 filter samples -> byte_done -> output register.
  localparam int LATENCY    = 2 + 8 + 2;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       code_valid;
  logic [7:0] code;
  logic       code_ext;
  logic       code_break;
  logic       frame_err;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         ext;
    bit         brk;
    bit         chk_lat;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_stop_cyc = 0;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;
  logic [7:0] m_last_code = 8'h00;
  bit         m_last_ext = 1'b0;
  bit         m_last_brk = 1'b0;

  ps2_scancode_rx #(
    .SYNC_STAGES    (2),
    .FILT_LEN       (8),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code_valid (code_valid),
    .code       (code),
    .code_ext   (code_ext),
    .code_break (code_break),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = (($countones(b) % 2) == 0) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  // Reference model of the prefix folding, fed one received frame at a time.
  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_q.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b1});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_q.push_back('{1'b0, b, m_ext, m_brk, 1'b1});
      m_last_code = b;
      m_last_ext  = m_ext;
      m_last_brk  = m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic hold_phase(input bit glitch);
    logic lvl;
    lvl = ps2_clk;
    for (int k = 0; k < HALF; k++) begin
      @(negedge clk);
      if (glitch && k == HALF / 2) ps2_clk = ~lvl;
      else ps2_clk = lvl;
    end
  endtask

  // Drive the first nbits bits of a frame; bus is left with ps2_clk high.
  task automatic applyStimulus(input logic [10:0] frame, input int nbits, input bit glitch);
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      hold_phase(glitch);
      ps2_clk = 1'b0;
      if (i == 10) last_stop_cyc = cyc;
      hold_phase(glitch);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    model_frame(b, !(bad_par || bad_stop));
    applyStimulus(make_frame(b, bad_par, bad_stop), 11, glitch);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_code_valid"}, 32'(code_valid), 32'd0);
    checkOutput({tag, "_code"}, 32'(code), 32'd0);
    checkOutput({tag, "_code_ext"}, 32'(code_ext), 32'd0);
    checkOutput({tag, "_code_break"}, 32'(code_break), 32'd0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  // Scoreboard: every output pulse must match the next expected event.
  always @(negedge clk) begin
    if (!sys_rst && (code_valid || frame_err)) begin
      checkOutput("valid_err_exclusive", 32'(code_valid & frame_err), 32'd0);
      if (exp_q.size() == 0) begin
        checkOutput("spurious_event", 32'({code_valid, frame_err}), 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        checkOutput("event_kind_err", 32'(frame_err), 32'(mon_ev.is_err));
        if (!mon_ev.is_err) begin
          checkOutput("code", 32'(code), 32'(mon_ev.code));
          checkOutput("code_ext", 32'(code_ext), 32'(mon_ev.ext));
          checkOutput("code_break", 32'(code_break), 32'(mon_ev.brk));
        end
        if (mon_ev.chk_lat) checkOutput("latency", 32'(cyc - last_stop_cyc), 32'(LATENCY));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    bit         bad;
    bit         which;
    bit         gl;

    // Reset state
    sys_rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    sys_rst = 1'b0;
    repeat (5) @(negedge clk);
    check_all_zero("after_reset");

    // Plain make code
    send_byte(8'h1C, 1'b0, 1'b0, 1'b0);

    // Break and extended-break sequences
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b0, 1'b0, 1'b0);
    send_byte(8'hE0, 1'b0, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h75, 1'b0, 1'b0, 1'b0);

    // Parity and stop errors, error clears pending prefix
    send_byte(8'h1C, 1'b1, 1'b0, 1'b0);
    send_byte(8'hE0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b1, 1'b0);
    send_byte(8'h75, 1'b0, 1'b0, 1'b0);

    // Timeout on a partial frame, with a pending prefix that must be dropped
    send_byte(8'hE0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
    m_ext = 1'b0;
    m_brk = 1'b0;
    applyStimulus(make_frame(8'h2B, 1'b0, 1'b0), 5, 1'b0);
    repeat (TB_TIMEOUT + 100) @(negedge clk);
    checkOutput("timeout_seen", 32'(exp_q.size()), 32'd0);
    send_byte(8'h2B, 1'b0, 1'b0, 1'b0);

    // Short low glitches on an idle bus, then glitchy frames
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    send_byte(8'h5A, 1'b0, 1'b0, 1'b1);
    send_byte(8'hE0, 1'b0, 1'b0, 1'b1);
    send_byte(8'h6B, 1'b0, 1'b0, 1'b1);

    // Reset between data bits 5 and 6, with a break prefix pending
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    applyStimulus(make_frame(8'h33, 1'b0, 1'b0), 6, 1'b0);
    sys_rst = 1'b1;
    #1;
    check_all_zero("midframe_reset");
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_last_code = 8'h00;
    m_last_ext  = 1'b0;
    m_last_brk  = 1'b0;
    @(negedge clk);
    sys_rst = 1'b0;
    repeat (10) @(negedge clk);
    send_byte(8'h1C, 1'b0, 1'b0, 1'b0);

    // Randomised byte stream with prefixes, occasional bad frames and glitches
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 9))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        2: rb = 8'hE1;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      bad   = ($urandom_range(0, 9) == 0);
      which = 1'($urandom_range(0, 1));
      gl    = ($urandom_range(0, 3) == 0);
      send_byte(rb, bad && which, bad && !which, gl);
    end

    repeat (50) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("code_hold", 32'(code), 32'(m_last_code));
    checkOutput("code_ext_hold", 32'(code_ext), 32'(m_last_ext));
    checkOutput("code_break_hold", 32'(code_break), 32'(m_last_brk));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
